// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and deframer state encoding; KEY_UP/KEY_DOWN are also used by the
// time-setting counters.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 deframer: pin synchronizers, ps2_clk falling-edge detect, 11-bit frame FSM and
// inter-edge watchdog that aborts stalled partial frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned    N       = 8,
    parameter int unsigned    TW      = 16,
    parameter logic [TW-1:0]  TIMEOUT = TW'(50000)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ps2_clk,
    input  logic         i_ps2_data,
    output logic [N-1:0] o_byte,
    output logic         o_byte_rdy,
    output logic         o_frame_err
);

    localparam int unsigned CW = $clog2(N);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    ps2_state_e    r_state;
    ps2_state_e    w_state_next;
    logic [N-1:0]  r_shift;
    logic [CW-1:0] r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_wdog;
    logic          w_fall;
    logic          w_data;
    logic          w_timeout;

    // Preset to 1 so reset looks like an idle bus and never fakes a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data    = r_dat_sync[1];
    assign w_timeout = (r_state != StIdle) && (r_wdog == TIMEOUT);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = StIdle;
        end else if (w_fall) begin
            case (r_state)
                StIdle:   if (!w_data) w_state_next = StData;
                StData:   if (r_bit_cnt == CW'(N - 1)) w_state_next = StParity;
                StParity: w_state_next = StStop;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        o_byte_rdy  = 1'b0;
        o_frame_err = 1'b0;
        if (w_timeout) begin
            o_frame_err = 1'b1;
        end else if (w_fall && (r_state == StStop)) begin
            if (w_data && (^{r_shift, r_parity})) o_byte_rdy  = 1'b1;
            else                                  o_frame_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if ((r_state == StIdle) || w_fall || w_timeout) r_wdog <= '0;
            else                                            r_wdog <= r_wdog + 1'b1;
            if (w_fall && !w_timeout) begin
                case (r_state)
                    StIdle:   r_bit_cnt <= '0;
                    StData: begin
                        r_shift   <= {w_data, r_shift[N-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    StParity: r_parity <= w_data;
                    default:  ;
                endcase
            end
        end
    end

    assign o_byte = r_shift;

endmodule

// File: rtl/rx_teclado_ps2.sv
// PS/2 keyboard receiver with break/extended-prefix filtering and one-cycle make-code strobe.
// Build option PS2_EXT_FILTER_EN: deliver E0-prefixed makes as base codes instead of dropping them.
module rx_teclado_ps2
    import ps2_pkg::*;
#(
    parameter int unsigned   N       = 8,
    parameter int unsigned   TW      = 16,
    parameter logic [TW-1:0] TIMEOUT = TW'(50000)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ps2_clk,
    input  logic         i_ps2_data,
    output logic [N-1:0] o_key_code,
    output logic         o_en_codigo,
    output logic         o_frame_err
);

    logic [N-1:0] w_byte;
    logic         w_byte_rdy;
    logic         w_frame_err;
    logic         r_brk;
    logic         r_ext;
    logic         w_brk_next;
    logic         w_ext_next;
    logic         w_accept;
    logic [N-1:0] r_key_code;
    logic         r_en_codigo;
    logic         r_frame_err;

    ps2_rx_frame #(
        .N       (N),
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_frame (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .o_byte      (w_byte),
        .o_byte_rdy  (w_byte_rdy),
        .o_frame_err (w_frame_err)
    );

    always_comb begin
        w_brk_next = r_brk;
        w_ext_next = r_ext;
        w_accept   = 1'b0;
        if (w_byte_rdy) begin
            if (w_byte == N'(PS2_BREAK)) begin
                w_brk_next = 1'b1;
            end else if (w_byte == N'(PS2_EXT)) begin
                w_ext_next = 1'b1;
            end else if (r_brk) begin
                // Released key code, plain or extended: swallow it.
                w_brk_next = 1'b0;
                w_ext_next = 1'b0;
            end else begin
`ifdef PS2_EXT_FILTER_EN
                w_accept   = 1'b1;
`else
                w_accept   = ~r_ext;
`endif
                w_ext_next = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_key_code  <= '0;
            r_en_codigo <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_brk       <= w_brk_next;
            r_ext       <= w_ext_next;
            r_en_codigo <= w_accept;
            r_frame_err <= w_frame_err;
            if (w_accept) r_key_code <= w_byte;
        end
    end

    assign o_key_code  = r_key_code;
    assign o_en_codigo = r_en_codigo;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_rx_teclado_ps2.sv
// Self-checking bench for rx_teclado_ps2: directed scenarios plus a random byte stream
// checked against a keyboard-protocol reference model.
module tb_rx_teclado_ps2;

    localparam int          HALF = 20;   // PS/2 half-period in clk cycles, kept short for runtime
    localparam int          GAP  = 100;
    localparam logic [15:0] TMO  = 16'd300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] key;
    logic       en;
    logic       ferr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_fall = 0;
    int t_stop = 0;
    int last_en_cyc = 0;
    int err_seen = 0;
    int dbl_en = 0;
    int dbl_err = 0;
    logic prev_en = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] obs_q[$];

    rx_teclado_ps2 #(
        .N       (8),
        .TW      (16),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2c),
        .i_ps2_data  (ps2d),
        .o_key_code  (key),
        .o_en_codigo (en),
        .o_frame_err (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en === 1'b1) begin
            obs_q.push_back(key);
            last_en_cyc = cyc;
            if (prev_en) dbl_en++;
        end
        if (ferr === 1'b1) begin
            err_seen++;
            if (prev_err) dbl_err++;
        end
        prev_en  = (en === 1'b1);
        prev_err = (ferr === 1'b1);
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device changes data while ps2_clk is high; the host samples on the falling edge.
    task automatic send_bit(input logic b);
        ps2d = b;
        tick(HALF);
        ps2c = 1'b0;
        t_fall = cyc;
        tick(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        t_stop = t_fall;
        ps2d = 1'b1;
        tick(GAP);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++; if (key !== 8'h00) begin n_errors++; $display("FAIL reset_key: got %h want 00", key); end
        n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b want 0", en); end
        n_checks++; if (ferr !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", ferr); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single();
        int q0 = obs_q.size();
        int e0 = err_seen;
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 1) begin n_errors++; $display("FAIL single_pulses: got %0d want 1", obs_q.size() - q0); end
        n_checks++; if (key !== 8'h75) begin n_errors++; $display("FAIL single_key: got %h want 75", key); end
        n_checks++; if (last_en_cyc !== t_stop + 3) begin n_errors++; $display("FAIL single_latency: got cycle %0d want %0d", last_en_cyc, t_stop + 3); end
        n_checks++; if (err_seen !== e0) begin n_errors++; $display("FAIL single_err: got %0d errs want %0d", err_seen, e0); end
        n_checks++; if (dbl_en !== 0) begin n_errors++; $display("FAIL single_width: got %0d double strobes want 0", dbl_en); end
    endtask

    task automatic test_release();
        int q0 = obs_q.size();
        send_frame(8'h72, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 1) begin n_errors++; $display("FAIL release_pulses: got %0d want 1", obs_q.size() - q0); end
        n_checks++; if (obs_q.size() > q0 && obs_q[q0] !== 8'h72) begin n_errors++; $display("FAIL release_code: got %h want 72", obs_q[q0]); end
        n_checks++; if (key !== 8'h72) begin n_errors++; $display("FAIL release_hold: got %h want 72", key); end
    endtask

    task automatic test_ext();
        int q0 = obs_q.size();
        int exp_n;
        logic [7:0] exp_key;
`ifdef PS2_EXT_FILTER_EN
        exp_n = 1; exp_key = 8'h75;
`else
        exp_n = 0; exp_key = key;
`endif
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== exp_n) begin n_errors++; $display("FAIL ext_pulses: got %0d want %0d", obs_q.size() - q0, exp_n); end
        n_checks++; if (key !== exp_key) begin n_errors++; $display("FAIL ext_key: got %h want %h", key, exp_key); end
        q0 = obs_q.size();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 0) begin n_errors++; $display("FAIL ext_release_pulses: got %0d want 0", obs_q.size() - q0); end
        n_checks++; if (key !== exp_key) begin n_errors++; $display("FAIL ext_release_key: got %h want %h", key, exp_key); end
    endtask

    task automatic test_frame_err();
        int q0 = obs_q.size();
        int e0 = err_seen;
        send_frame(8'h75, 1'b1, 1'b0);
        n_checks++; if (err_seen - e0 !== 1) begin n_errors++; $display("FAIL parity_err: got %0d pulses want 1", err_seen - e0); end
        n_checks++; if (obs_q.size() - q0 !== 0) begin n_errors++; $display("FAIL parity_no_en: got %0d pulses want 0", obs_q.size() - q0); end
        send_frame(8'h33, 1'b0, 1'b1);
        n_checks++; if (err_seen - e0 !== 2) begin n_errors++; $display("FAIL stop_err: got %0d pulses want 2", err_seen - e0); end
        send_frame(8'h72, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 1 || key !== 8'h72) begin n_errors++; $display("FAIL after_err_accept: got %0d pulses key %h want 1 key 72", obs_q.size() - q0, key); end
        n_checks++; if (dbl_err !== 0) begin n_errors++; $display("FAIL err_width: got %0d double pulses want 0", dbl_err); end
    endtask

    task automatic test_timeout();
        int q0 = obs_q.size();
        int e0 = err_seen;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        ps2d = 1'b1;
        tick(200);
        n_checks++; if (err_seen !== e0) begin n_errors++; $display("FAIL timeout_early: got %0d pulses want 0", err_seen - e0); end
        tick(150);
        n_checks++; if (err_seen - e0 !== 1) begin n_errors++; $display("FAIL timeout_err: got %0d pulses want 1", err_seen - e0); end
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 1 || key !== 8'h75) begin n_errors++; $display("FAIL timeout_recover: got %0d pulses key %h want 1 key 75", obs_q.size() - q0, key); end
    endtask

    task automatic test_reset_mid();
        int q0;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick(1);
        n_checks++; if (key !== 8'h00) begin n_errors++; $display("FAIL midrst_key: got %h want 00", key); end
        n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL midrst_en: got %b want 0", en); end
        n_checks++; if (ferr !== 1'b0) begin n_errors++; $display("FAIL midrst_err: got %b want 0", ferr); end
        rst = 1'b0;
        ps2d = 1'b1;
        tick(10);
        q0 = obs_q.size();
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() - q0 !== 1) begin n_errors++; $display("FAIL midrst_pulses: got %0d want 1", obs_q.size() - q0); end
        n_checks++; if (key !== 8'h75) begin n_errors++; $display("FAIL midrst_key_after: got %h want 75", key); end
    endtask

    // Reference: keyboard protocol rules applied to the list of correctly framed bytes.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       bad_p, bad_s;
        logic       pend_brk = 1'b0;
        logic       pend_ext = 1'b0;
        logic [7:0] exp_key = key;
        int q0 = obs_q.size();
        int e0 = err_seen;
        int exp_err = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hF0;
                2:       b = 8'hE0;
                3:       b = 8'h75;
                4:       b = 8'h72;
                default: b = 8'($urandom);
            endcase
            bad_p = ($urandom_range(0, 9) == 0);
            bad_s = !bad_p && ($urandom_range(0, 14) == 0);
            send_frame(b, bad_p, bad_s);
            if (bad_p || bad_s) begin
                exp_err++;
            end else if (b == 8'hF0) begin
                pend_brk = 1'b1;
            end else if (b == 8'hE0) begin
                pend_ext = 1'b1;
            end else begin
`ifdef PS2_EXT_FILTER_EN
                if (!pend_brk) begin exp_q.push_back(b); exp_key = b; end
`else
                if (!pend_brk && !pend_ext) begin exp_q.push_back(b); exp_key = b; end
`endif
                pend_brk = 1'b0;
                pend_ext = 1'b0;
            end
        end
        n_checks++; if (obs_q.size() - q0 !== exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d strobes want %0d", obs_q.size() - q0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && q0 + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[q0 + i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rand_code[%0d]: got %h want %h", i, obs_q[q0 + i], exp_q[i]);
            end
        end
        n_checks++; if (err_seen - e0 !== exp_err) begin n_errors++; $display("FAIL rand_errs: got %0d want %0d", err_seen - e0, exp_err); end
        n_checks++; if (key !== exp_key) begin n_errors++; $display("FAIL rand_key: got %h want %h", key, exp_key); end
        n_checks++; if (dbl_en !== 0) begin n_errors++; $display("FAIL rand_width: got %0d double strobes want 0", dbl_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_release();
        test_ext();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
